// File: rtl/synth_core.sv
// synth_core: polyphonic voice engine. Each of NUM_UNITS voices is a phase-accumulator
// oscillator, an ADSR envelope and a mixer gain. The voices are summed into one signed
// sample stream.
// Ports:
//   ctl_clk, ctl_rst          - clock and synchronous active-high reset
//   vco_freq_in/vco_wave_type - per-voice frequency in Hz and wave select
//                               (0 square, 1 saw, 2 triangle, 3 silent)
//   vca_*_in                  - per-voice attack/decay/sustain/release bytes
//   amp_in                    - per-voice mixer gain, Q.FIXED_POINT
//   trigger                   - per-voice gate (level sensitive)
//   aud_freq                  - sample tick enable
//   ch_in_use                 - voice envelope is not idle
//   wave_out                  - mixed sample
// Build option: define SYNTH_SATURATE_EN to clamp the mix instead of wrapping it.
module synth_core #(
  parameter int unsigned BITWIDTH      = 24,
  parameter int unsigned FIXED_POINT   = 8,
  parameter int unsigned NUM_UNITS     = 4,
  parameter int unsigned FREQ_WIDTH    = 16,
  parameter int unsigned AMP_WIDTH     = 16,
  parameter int unsigned PHASE_WIDTH   = 32,
  parameter int unsigned PHASE_INC_MUL = 89478,
  parameter int unsigned ENV_SHIFT     = 4
) (
  input  logic                             ctl_clk,
  input  logic                             ctl_rst,
  input  logic [FREQ_WIDTH*NUM_UNITS-1:0]  vco_freq_in,
  input  logic [2*NUM_UNITS-1:0]           vco_wave_type,
  input  logic [FIXED_POINT*NUM_UNITS-1:0] vca_attack_in,
  input  logic [FIXED_POINT*NUM_UNITS-1:0] vca_decay_in,
  input  logic [FIXED_POINT*NUM_UNITS-1:0] vca_sustain_in,
  input  logic [FIXED_POINT*NUM_UNITS-1:0] vca_release_in,
  input  logic [AMP_WIDTH*NUM_UNITS-1:0]   amp_in,
  input  logic [NUM_UNITS-1:0]             trigger,
  input  logic                             aud_freq,
  output logic [NUM_UNITS-1:0]             ch_in_use,
  output logic [BITWIDTH-1:0]              wave_out
);

  localparam int unsigned ENV_W = 24;
  localparam int unsigned EP_W  = BITWIDTH + ENV_W + 1;
  localparam int unsigned MP_W  = BITWIDTH + AMP_WIDTH + 1;
  localparam int unsigned ACC_W = BITWIDTH + AMP_WIDTH + $clog2(NUM_UNITS) + 1;

  localparam logic [ENV_W-1:0]             ENV_FULL = '1;
  localparam logic [PHASE_WIDTH-1:0]       INC_MUL  = PHASE_WIDTH'(PHASE_INC_MUL);
  localparam logic signed [BITWIDTH-1:0]   SQ_POS   = {1'b0, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [BITWIDTH-1:0]   SQ_NEG   = {1'b1, {(BITWIDTH-2){1'b0}}, 1'b1};
`ifdef SYNTH_SATURATE_EN
  localparam logic signed [ACC_W-1:0]      SAT_MAX  = {{(ACC_W-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]      SAT_MIN  = ~SAT_MAX;
`endif

  typedef enum logic [2:0] {
    EG_IDLE,
    EG_ATTACK,
    EG_DECAY,
    EG_SUSTAIN,
    EG_RELEASE
  } eg_state_e;

  eg_state_e                state_q    [NUM_UNITS];
  eg_state_e                state_d    [NUM_UNITS];
  logic [ENV_W-1:0]         env_q      [NUM_UNITS];
  logic [ENV_W-1:0]         env_d      [NUM_UNITS];
  logic [PHASE_WIDTH-1:0]   phase_q    [NUM_UNITS];
  logic [PHASE_WIDTH-1:0]   phase_d    [NUM_UNITS];
  logic [1:0]               wave_sel_q [NUM_UNITS];
  logic [1:0]               wave_sel_d [NUM_UNITS];
  logic [AMP_WIDTH-1:0]     amp_q      [NUM_UNITS];
  logic [AMP_WIDTH-1:0]     amp_d      [NUM_UNITS];
  logic [NUM_UNITS-1:0]     gate_q, gate_d;
  logic                     tick_q, tick_d;
  logic [BITWIDTH-1:0]      wave_out_q, wave_out_d;

  logic [ENV_W:0]           eg_sum, eg_sus;
  logic [BITWIDTH-1:0]      p, q;
  logic signed [BITWIDTH-1:0] wave_s, voice;
  logic signed [EP_W-1:0]   env_prod;
  logic signed [MP_W-1:0]   mix_prod;
  logic signed [ACC_W-1:0]  acc;
  logic [BITWIDTH-1:0]      mix_out;

  function automatic logic [ENV_W:0] eg_step(input logic [FIXED_POINT-1:0] rate);
    logic [ENV_W:0] base;
    base = ((ENV_W+1)'(1) << FIXED_POINT) - (ENV_W+1)'(rate);
    return base << ENV_SHIFT;
  endfunction

  always_ff @(posedge ctl_clk) begin
    if (ctl_rst) begin
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
        state_q[i]    <= EG_IDLE;
        env_q[i]      <= '0;
        phase_q[i]    <= '0;
        wave_sel_q[i] <= '0;
        amp_q[i]      <= '0;
      end
      gate_q     <= '0;
      tick_q     <= 1'b0;
      wave_out_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
        state_q[i]    <= state_d[i];
        env_q[i]      <= env_d[i];
        phase_q[i]    <= phase_d[i];
        wave_sel_q[i] <= wave_sel_d[i];
        amp_q[i]      <= amp_d[i];
      end
      gate_q     <= gate_d;
      tick_q     <= tick_d;
      wave_out_q <= wave_out_d;
    end
  end

  always_comb begin
    gate_d = gate_q;
    tick_d = aud_freq;
    eg_sum = '0;
    eg_sus = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      state_d[i]    = state_q[i];
      env_d[i]      = env_q[i];
      phase_d[i]    = phase_q[i];
      wave_sel_d[i] = wave_sel_q[i];
      amp_d[i]      = amp_q[i];
      if (aud_freq) begin
        phase_d[i]    = phase_q[i] + PHASE_WIDTH'(vco_freq_in[FREQ_WIDTH*i +: FREQ_WIDTH]) * INC_MUL;
        wave_sel_d[i] = vco_wave_type[2*i +: 2];
        amp_d[i]      = amp_in[AMP_WIDTH*i +: AMP_WIDTH];
        gate_d[i]     = trigger[i];
        eg_sus        = (ENV_W+1)'({3{vca_sustain_in[FIXED_POINT*i +: FIXED_POINT]}});
        if (trigger[i] && !gate_q[i]) begin
          state_d[i] = EG_ATTACK;
        end else if (!trigger[i] && (state_q[i] inside {EG_ATTACK, EG_DECAY, EG_SUSTAIN})) begin
          state_d[i] = EG_RELEASE;
        end else begin
          case (state_q[i])
            EG_ATTACK: begin
              eg_sum = {1'b0, env_q[i]} + eg_step(vca_attack_in[FIXED_POINT*i +: FIXED_POINT]);
              if (eg_sum >= {1'b0, ENV_FULL}) begin
                env_d[i]   = ENV_FULL;
                state_d[i] = EG_DECAY;
              end else begin
                env_d[i] = ENV_W'(eg_sum);
              end
            end
            EG_DECAY: begin
              eg_sum = eg_sus + eg_step(vca_decay_in[FIXED_POINT*i +: FIXED_POINT]);
              if ({1'b0, env_q[i]} <= eg_sum) begin
                env_d[i]   = ENV_W'(eg_sus);
                state_d[i] = EG_SUSTAIN;
              end else begin
                env_d[i] = env_q[i] - ENV_W'(eg_step(vca_decay_in[FIXED_POINT*i +: FIXED_POINT]));
              end
            end
            EG_SUSTAIN: env_d[i] = ENV_W'(eg_sus);
            EG_RELEASE: begin
              eg_sum = eg_step(vca_release_in[FIXED_POINT*i +: FIXED_POINT]);
              if ({1'b0, env_q[i]} <= eg_sum) begin
                env_d[i]   = '0;
                state_d[i] = EG_IDLE;
              end else begin
                env_d[i] = env_q[i] - ENV_W'(eg_sum);
              end
            end
            default: env_d[i] = '0;
          endcase
        end
      end
    end
  end

  // Mix is formed from the registered voice state and lands one edge after the tick.
  always_comb begin
    acc    = '0;
    p      = '0;
    q      = '0;
    wave_s = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      p = phase_q[i][PHASE_WIDTH-1 -: BITWIDTH];
      q = '0;
      q[BITWIDTH-2:0] = p[BITWIDTH-1] ? ~p[BITWIDTH-2:0] : p[BITWIDTH-2:0];
      case (wave_sel_q[i])
        2'd0:    wave_s = p[BITWIDTH-1] ? SQ_NEG : SQ_POS;
        2'd1:    wave_s = {~p[BITWIDTH-1], p[BITWIDTH-2:0]};
        2'd2:    wave_s = {~q[BITWIDTH-2], q[BITWIDTH-3:0], 1'b0};
        default: wave_s = '0;
      endcase
      env_prod = EP_W'(wave_s) * EP_W'($signed({1'b0, env_q[i]}));
      voice    = BITWIDTH'(env_prod >>> ENV_W);
      mix_prod = MP_W'(voice) * MP_W'($signed({1'b0, amp_q[i]}));
      acc      = acc + ACC_W'(mix_prod >>> FIXED_POINT);
      ch_in_use[i] = (state_q[i] != EG_IDLE);
    end
`ifdef SYNTH_SATURATE_EN
    if (acc > SAT_MAX) begin
      mix_out = BITWIDTH'(SAT_MAX);
    end else if (acc < SAT_MIN) begin
      mix_out = BITWIDTH'(SAT_MIN);
    end else begin
      mix_out = BITWIDTH'(acc);
    end
`else
    mix_out = BITWIDTH'(acc);
`endif
    wave_out_d = tick_q ? mix_out : wave_out_q;
  end

  assign wave_out = wave_out_q;

endmodule

// File: tb/tb_synth_core.sv
module tb_synth_core;

  localparam int NU = 4;

  typedef enum int {M_IDLE, M_ATTACK, M_DECAY, M_SUSTAIN, M_RELEASE} m_state_e;

  logic        ctl_clk = 1'b0;
  logic        ctl_rst;
  logic [63:0] vco_freq_in;
  logic [7:0]  vco_wave_type;
  logic [31:0] vca_attack_in, vca_decay_in, vca_sustain_in, vca_release_in;
  logic [63:0] amp_in;
  logic [3:0]  trigger;
  logic        aud_freq;
  logic [3:0]  ch_in_use;
  logic [23:0] wave_out;

  int freq [NU], wtype [NU], att [NU], dec [NU], sus [NU], rel [NU], amp [NU];

  m_state_e    m_st [NU];
  longint      m_L  [NU];
  longint      m_ph [NU];
  bit          m_gp [NU];
  bit          m_tick_prev;
  logic [23:0] last_wave;
  logic [23:0] sbq [$];
  int          checks   = 0;
  int          failures = 0;

  synth_core dut (
    .ctl_clk        (ctl_clk),
    .ctl_rst        (ctl_rst),
    .vco_freq_in    (vco_freq_in),
    .vco_wave_type  (vco_wave_type),
    .vca_attack_in  (vca_attack_in),
    .vca_decay_in   (vca_decay_in),
    .vca_sustain_in (vca_sustain_in),
    .vca_release_in (vca_release_in),
    .amp_in         (amp_in),
    .trigger        (trigger),
    .aud_freq       (aud_freq),
    .ch_in_use      (ch_in_use),
    .wave_out       (wave_out)
  );

  always #5 ctl_clk = ~ctl_clk;

  always_comb begin
    vco_freq_in    = '0;
    vco_wave_type  = '0;
    vca_attack_in  = '0;
    vca_decay_in   = '0;
    vca_sustain_in = '0;
    vca_release_in = '0;
    amp_in         = '0;
    for (int i = 0; i < NU; i++) begin
      vco_freq_in[16*i +: 16]   = 16'(freq[i]);
      vco_wave_type[2*i +: 2]   = 2'(wtype[i]);
      vca_attack_in[8*i +: 8]   = 8'(att[i]);
      vca_decay_in[8*i +: 8]    = 8'(dec[i]);
      vca_sustain_in[8*i +: 8]  = 8'(sus[i]);
      vca_release_in[8*i +: 8]  = 8'(rel[i]);
      amp_in[16*i +: 16]        = 16'(amp[i]);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint stepf(input int r);
    return longint'((256 - r) * 16);
  endfunction

  function automatic longint m_wave(input int i);
    longint p, q;
    p = (m_ph[i] >> 8) & 64'hFF_FFFF;
    case (wtype[i])
      0: return (p < 8388608) ? 64'sd8388607 : -64'sd8388607;
      1: return p - 8388608;
      2: begin
        q = (p < 8388608) ? p : 16777215 - p;
        return 2 * q - 8388608;
      end
      default: return 0;
    endcase
  endfunction

  function automatic logic [23:0] m_mix();
    longint acc, v;
    acc = 0;
    for (int i = 0; i < NU; i++) begin
      v   = (m_wave(i) * m_L[i]) >>> 24;
      acc = acc + ((v * longint'(amp[i])) >>> 8);
    end
`ifdef SYNTH_SATURATE_EN
    if (acc > 8388607)  acc = 8388607;
    if (acc < -8388608) acc = -8388608;
`endif
    return 24'(acc);
  endfunction

  function automatic logic [3:0] m_ch();
    logic [3:0] c;
    for (int i = 0; i < NU; i++) c[i] = (m_st[i] != M_IDLE);
    return c;
  endfunction

  task automatic model_tick();
    longint s_lvl;
    bit g;
    for (int i = 0; i < NU; i++) begin
      g     = trigger[i];
      s_lvl = longint'(sus[i]) * 65793;
      if (g && !m_gp[i]) begin
        m_st[i] = M_ATTACK;
      end else if (!g && (m_st[i] == M_ATTACK || m_st[i] == M_DECAY || m_st[i] == M_SUSTAIN)) begin
        m_st[i] = M_RELEASE;
      end else begin
        case (m_st[i])
          M_ATTACK:
            if (m_L[i] + stepf(att[i]) >= 16777215) begin
              m_L[i] = 16777215; m_st[i] = M_DECAY;
            end else m_L[i] = m_L[i] + stepf(att[i]);
          M_DECAY:
            if (m_L[i] - stepf(dec[i]) <= s_lvl) begin
              m_L[i] = s_lvl; m_st[i] = M_SUSTAIN;
            end else m_L[i] = m_L[i] - stepf(dec[i]);
          M_SUSTAIN: m_L[i] = s_lvl;
          M_RELEASE:
            if (m_L[i] - stepf(rel[i]) <= 0) begin
              m_L[i] = 0; m_st[i] = M_IDLE;
            end else m_L[i] = m_L[i] - stepf(rel[i]);
          default: m_L[i] = 0;
        endcase
      end
      m_gp[i] = g;
      m_ph[i] = (m_ph[i] + longint'(freq[i]) * 89478) & 64'hFFFF_FFFF;
    end
  endtask

  task automatic cycle();
    @(posedge ctl_clk);
    if (aud_freq) model_tick();
    #1;
    check("ch_in_use", 32'(ch_in_use), 32'(m_ch()));
    if (m_tick_prev) begin
      checks++;
      assert (sbq.size() > 0) else begin
        failures++;
        $error("FAIL scoreboard_empty observed=%0d expected=1", sbq.size());
      end
      if (sbq.size() > 0) last_wave = sbq.pop_front();
    end
    check("wave_out", 32'(wave_out), 32'(last_wave));
    if (aud_freq) sbq.push_back(m_mix());
    m_tick_prev = aud_freq;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_reset();
    ctl_rst = 1'b1;
    @(posedge ctl_clk);
    for (int i = 0; i < NU; i++) begin
      m_st[i] = M_IDLE; m_L[i] = 0; m_ph[i] = 0; m_gp[i] = 1'b0;
    end
    sbq.delete();
    last_wave   = '0;
    m_tick_prev = 1'b0;
    #1;
    check("reset_wave_out", 32'(wave_out), 32'h0);
    check("reset_ch_in_use", 32'(ch_in_use), 32'h0);
    ctl_rst = 1'b0;
  endtask

  task automatic set_voice(input int i, input int f, input int w, input int a, input int d,
                           input int s, input int r, input int g);
    freq[i] = f; wtype[i] = w; att[i] = a; dec[i] = d; sus[i] = s; rel[i] = r; amp[i] = g;
  endtask

  initial begin
    ctl_rst  = 1'b1;
    aud_freq = 1'b1;
    trigger  = '0;
    for (int i = 0; i < NU; i++) set_voice(i, 0, 0, 0, 0, 0, 0, 0);

    // Idle after reset
    do_reset();
    run(1000);

    // Voice 0 square 8 kHz, slow attack
    set_voice(0, 8000, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'h100);
    trigger[0] = 1'b1;
    cycle();
    check("v0_inuse_first_tick", 32'(ch_in_use[0]), 32'h1);
    run(40);

    // Tick enable low: everything holds
    aud_freq = 1'b0;
    run(5);
    aud_freq = 1'b1;
    run(5);

    // Voices 1 and 3 in use but muted by zero gain
    set_voice(1, 3000, 2, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0);
    set_voice(2, 1000, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'h100);
    set_voice(3, 5000, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0);
    trigger = 4'b1111;
    cycle();
    check("all_voices_in_use", 32'(ch_in_use), 32'hF);
    run(60);

    // Reset mid-note with gate still high, then full ADSR on voice 0
    set_voice(0, 440, 2, 8'h00, 8'h10, 8'h08, 8'hF0, 16'h100);
    for (int i = 1; i < NU; i++) set_voice(i, 0, 0, 0, 0, 0, 0, 0);
    trigger = 4'b0001;
    do_reset();
    cycle();
    check("v0_attack_after_reset", 32'(ch_in_use), 32'h1);
    run(4096 + 4300);

    // Release from sustain
    trigger[0] = 1'b0;
    run(2065);
    check("v0_idle_after_release", 32'(ch_in_use), 32'h0);
    check("v0_silent_after_release", 32'(wave_out), 32'h0);

    // Four saw voices at full level and maximum gain
    for (int i = 0; i < NU; i++) set_voice(i, 0, 1, 8'h00, 8'hFF, 8'hFF, 8'hFF, 16'hFFFF);
    do_reset();
    trigger = 4'b1111;
    run(4120);
`ifdef SYNTH_SATURATE_EN
    check("mix_saturated", 32'(wave_out), 32'h800000);
`else
    check("mix_wrapped", 32'(wave_out), 32'h020000);
`endif
    for (int i = 0; i < NU; i++) freq[i] = 12000;
    run(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
